id_ex_stage: RTL and testbench

- Decode-to-execute pipeline register for the 64-bit pipelined core. It sits directly downstream of the register file.
- Captures BusA/BusB read data, the sign-extended immediate, register specifiers and decode control into EX.
- Contains the load-use hazard detector. On a hazard it stalls PC/IF-ID and injects a bubble into EX.
- Handles branch flush and downstream hold, and keeps a saturating bubble counter for performance analysis.

---
 rtl/id_ex_stage.sv | 120 ++++++++++++
 tb/tb_id_ex_stage.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush/hold handling
// and a saturating count of inserted load-use bubbles.
module id_ex_stage #(
  parameter int CTRL_W = 12,
  parameter int CNT_W  = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [63:0]       BusA_in,
  input  logic [63:0]       BusB_in,
  input  logic [63:0]       Imm_in,
  input  logic [4:0]        RA_in,
  input  logic [4:0]        RB_in,
  input  logic [4:0]        RW_in,
  input  logic              UsesA_in,
  input  logic              UsesB_in,
  input  logic              MemRead_in,
  input  logic [CTRL_W-1:0] Ctrl_in,
  input  logic              Valid_in,
  input  logic              Flush,
  input  logic              Hold,
  output logic [63:0]       BusA_out,
  output logic [63:0]       BusB_out,
  output logic [63:0]       Imm_out,
  output logic [4:0]        RA_out,
  output logic [4:0]        RB_out,
  output logic [4:0]        RW_out,
  output logic              MemRead_out,
  output logic [CTRL_W-1:0] Ctrl_out,
  output logic              Valid_out,
  output logic              Stall,
  output logic [CNT_W-1:0]  BubbleCount
);

  logic [63:0]       busa_q, busa_d, busb_q, busb_d, imm_q, imm_d;
  logic [4:0]        ra_q, ra_d, rb_q, rb_d, rw_q, rw_d;
  logic              memread_q, memread_d, valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              hz;

  // XZR (r31) is never a real load destination, so it cannot create a hazard.
  assign hz = valid_q && memread_q && (rw_q != 5'd31) && Valid_in &&
              ((UsesA_in && (RA_in == rw_q)) || (UsesB_in && (RB_in == rw_q)));
  assign Stall = hz && !Flush && !Hold;

  always_comb begin
    busa_d    = busa_q;
    busb_d    = busb_q;
    imm_d     = imm_q;
    ra_d      = ra_q;
    rb_d      = rb_q;
    rw_d      = rw_q;
    memread_d = memread_q;
    valid_d   = valid_q;
    ctrl_d    = ctrl_q;
    cnt_d     = cnt_q;
    if (Flush || (!Hold && hz)) begin
      busa_d    = '0;
      busb_d    = '0;
      imm_d     = '0;
      ra_d      = '0;
      rb_d      = '0;
      rw_d      = 5'd31;
      memread_d = 1'b0;
      valid_d   = 1'b0;
      ctrl_d    = '0;
    end else if (!Hold) begin
      busa_d    = BusA_in;
      busb_d    = BusB_in;
      imm_d     = Imm_in;
      ra_d      = RA_in;
      rb_d      = RB_in;
      rw_d      = RW_in;
      valid_d   = Valid_in;
      memread_d = Valid_in && MemRead_in;
      ctrl_d    = Valid_in ? Ctrl_in : '0;
    end
    // Only bubbles actually inserted for load-use count; flush bubbles do not.
    if (Stall && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      busa_q    <= '0;
      busb_q    <= '0;
      imm_q     <= '0;
      ra_q      <= '0;
      rb_q      <= '0;
      rw_q      <= '0;
      memread_q <= 1'b0;
      valid_q   <= 1'b0;
      ctrl_q    <= '0;
      cnt_q     <= '0;
    end else begin
      busa_q    <= busa_d;
      busb_q    <= busb_d;
      imm_q     <= imm_d;
      ra_q      <= ra_d;
      rb_q      <= rb_d;
      rw_q      <= rw_d;
      memread_q <= memread_d;
      valid_q   <= valid_d;
      ctrl_q    <= ctrl_d;
      cnt_q     <= cnt_d;
    end
  end

  assign BusA_out    = busa_q;
  assign BusB_out    = busb_q;
  assign Imm_out     = imm_q;
  assign RA_out      = ra_q;
  assign RB_out      = rb_q;
  assign RW_out      = rw_q;
  assign MemRead_out = memread_q;
  assign Ctrl_out    = ctrl_q;
  assign Valid_out   = valid_q;
  assign BubbleCount = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vectors, a per-cycle reference model, and a
// second narrow-counter instance that shares all inputs to show saturation.
module tb_id_ex_stage;
  localparam int CTRL_W = 12;

  logic              Clk = 1'b0;
  logic              Reset;
  logic [63:0]       BusA_in, BusB_in, Imm_in;
  logic [4:0]        RA_in, RB_in, RW_in;
  logic              UsesA_in, UsesB_in, MemRead_in, Valid_in, Flush, Hold;
  logic [CTRL_W-1:0] Ctrl_in;

  logic [63:0]       BusA_out, BusB_out, Imm_out;
  logic [4:0]        RA_out, RB_out, RW_out;
  logic              MemRead_out, Valid_out, Stall;
  logic [CTRL_W-1:0] Ctrl_out;
  logic [31:0]       BubbleCount;

  logic [63:0]       s_busa, s_busb, s_imm;
  logic [4:0]        s_ra, s_rb, s_rw;
  logic              s_memread, s_valid, s_stall;
  logic [CTRL_W-1:0] s_ctrl;
  logic [1:0]        s_count;

  int checks = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  id_ex_stage #(.CTRL_W(CTRL_W), .CNT_W(32)) dut (
    .Clk(Clk), .Reset(Reset), .BusA_in(BusA_in), .BusB_in(BusB_in), .Imm_in(Imm_in),
    .RA_in(RA_in), .RB_in(RB_in), .RW_in(RW_in), .UsesA_in(UsesA_in), .UsesB_in(UsesB_in),
    .MemRead_in(MemRead_in), .Ctrl_in(Ctrl_in), .Valid_in(Valid_in), .Flush(Flush), .Hold(Hold),
    .BusA_out(BusA_out), .BusB_out(BusB_out), .Imm_out(Imm_out), .RA_out(RA_out),
    .RB_out(RB_out), .RW_out(RW_out), .MemRead_out(MemRead_out), .Ctrl_out(Ctrl_out),
    .Valid_out(Valid_out), .Stall(Stall), .BubbleCount(BubbleCount));

  id_ex_stage #(.CTRL_W(CTRL_W), .CNT_W(2)) dut_sat (
    .Clk(Clk), .Reset(Reset), .BusA_in(BusA_in), .BusB_in(BusB_in), .Imm_in(Imm_in),
    .RA_in(RA_in), .RB_in(RB_in), .RW_in(RW_in), .UsesA_in(UsesA_in), .UsesB_in(UsesB_in),
    .MemRead_in(MemRead_in), .Ctrl_in(Ctrl_in), .Valid_in(Valid_in), .Flush(Flush), .Hold(Hold),
    .BusA_out(s_busa), .BusB_out(s_busb), .Imm_out(s_imm), .RA_out(s_ra),
    .RB_out(s_rb), .RW_out(s_rw), .MemRead_out(s_memread), .Ctrl_out(s_ctrl),
    .Valid_out(s_valid), .Stall(s_stall), .BubbleCount(s_count));

  // Reference model: what EX should hold, tracked as plain variables.
  logic [63:0]       m_busa, m_busb, m_imm;
  logic [4:0]        m_ra, m_rb, m_rw;
  logic              m_memread, m_valid;
  logic [CTRL_W-1:0] m_ctrl;
  longint            m_bubbles;
  bit                model_ok = 0;

  function automatic bit model_depends();
    bit reads_dest;
    reads_dest = (UsesA_in && RA_in == m_rw) || (UsesB_in && RB_in == m_rw);
    return m_valid && m_memread && m_rw != 5'd31 && Valid_in && reads_dest;
  endfunction

  function automatic bit model_stall();
    return model_depends() && !Flush && !Hold;
  endfunction

  task automatic model_bubble();
    {m_busa, m_busb, m_imm} = '0;
    {m_ra, m_rb} = '0;
    m_rw = 5'd31; m_memread = 0; m_valid = 0; m_ctrl = '0;
  endtask

  always @(posedge Clk) begin
    if (Reset) begin
      {m_busa, m_busb, m_imm} = '0;
      {m_ra, m_rb, m_rw} = '0;
      m_memread = 0; m_valid = 0; m_ctrl = '0; m_bubbles = 0;
      model_ok = 1;
    end else if (Flush) begin
      model_bubble();
    end else if (Hold) begin
      // EX keeps everything
    end else if (model_depends()) begin
      model_bubble();
      m_bubbles++;
    end else begin
      m_busa = BusA_in; m_busb = BusB_in; m_imm = Imm_in;
      m_ra = RA_in; m_rb = RB_in; m_rw = RW_in;
      m_valid = Valid_in;
      m_memread = Valid_in ? MemRead_in : 1'b0;
      m_ctrl = Valid_in ? Ctrl_in : '0;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (model_ok) begin
      chk("cyc_busa", BusA_out, m_busa);
      chk("cyc_busb", BusB_out, m_busb);
      chk("cyc_imm", Imm_out, m_imm);
      chk("cyc_ra", 64'(RA_out), 64'(m_ra));
      chk("cyc_rb", 64'(RB_out), 64'(m_rb));
      chk("cyc_rw", 64'(RW_out), 64'(m_rw));
      chk("cyc_memread", 64'(MemRead_out), 64'(m_memread));
      chk("cyc_ctrl", 64'(Ctrl_out), 64'(m_ctrl));
      chk("cyc_valid", 64'(Valid_out), 64'(m_valid));
      chk("cyc_stall", 64'(Stall), 64'(model_stall()));
      chk("cyc_count", 64'(BubbleCount), 64'(m_bubbles));
      chk("cyc_sat_count", 64'(s_count), (m_bubbles > 3) ? 64'd3 : 64'(m_bubbles));
      chk("cyc_sat_stall", 64'(s_stall), 64'(model_stall()));
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    BusA_in = '0; BusB_in = '0; Imm_in = '0;
    RA_in = '0; RB_in = '0; RW_in = '0;
    UsesA_in = 0; UsesB_in = 0; MemRead_in = 0; Ctrl_in = '0;
    Valid_in = 0; Flush = 0; Hold = 0;
  endtask

  task automatic load(input logic [4:0] rw);
    idle();
    Valid_in = 1; MemRead_in = 1; RW_in = rw; Ctrl_in = 12'h5A5;
  endtask

  task automatic user_a(input logic [4:0] ra, input logic [63:0] a);
    idle();
    Valid_in = 1; UsesA_in = 1; RA_in = ra; RW_in = 5'd7; BusA_in = a; Ctrl_in = 12'h111;
  endtask

  initial begin
    idle();
    Reset = 1;
    tick(); tick();
    Reset = 0;
    chk("rst_valid", 64'(Valid_out), 64'd0);
    chk("rst_count", 64'(BubbleCount), 64'd0);
    chk("rst_stall", 64'(Stall), 64'd0);
    chk("rst_rw", 64'(RW_out), 64'd0);

    // Basic capture
    idle(); Valid_in = 1; BusA_in = 64'h1234; RW_in = 5'd5;
    tick();
    chk("cap_busa", BusA_out, 64'h1234);
    chk("cap_rw", 64'(RW_out), 64'd5);
    chk("cap_valid", 64'(Valid_out), 64'd1);
    chk("cap_stall", 64'(Stall), 64'd0);

    // Load-use: exactly one bubble, then the dependent instruction advances
    load(5'd3); tick();
    chk("lu_memread", 64'(MemRead_out), 64'd1);
    user_a(5'd3, 64'h55); #1;
    chk("lu_stall", 64'(Stall), 64'd1);
    tick();
    chk("lu_bub_valid", 64'(Valid_out), 64'd0);
    chk("lu_bub_ctrl", 64'(Ctrl_out), 64'd0);
    chk("lu_bub_rw", 64'(RW_out), 64'd31);
    chk("lu_count", 64'(BubbleCount), 64'd1);
    chk("lu_stall_after", 64'(Stall), 64'd0);
    tick();
    chk("lu_dep_busa", BusA_out, 64'h55);
    chk("lu_dep_rw", 64'(RW_out), 64'd7);
    chk("lu_dep_valid", 64'(Valid_out), 64'd1);

    // Load to XZR never stalls
    load(5'd31); tick();
    user_a(5'd31, 64'h77); #1;
    chk("x31_stall", 64'(Stall), 64'd0);
    tick();
    chk("x31_valid", 64'(Valid_out), 64'd1);
    chk("x31_count", 64'(BubbleCount), 64'd1);

    // Flush beats a hazard and is not counted
    load(5'd4); tick();
    idle(); Valid_in = 1; UsesB_in = 1; RB_in = 5'd4; Flush = 1; #1;
    chk("fl_stall", 64'(Stall), 64'd0);
    tick();
    chk("fl_valid", 64'(Valid_out), 64'd0);
    chk("fl_count", 64'(BubbleCount), 64'd1);

    // Invalid ID slot forces control to zero
    idle(); MemRead_in = 1; Ctrl_in = 12'hFFF; BusA_in = 64'hAB; tick();
    chk("inv_ctrl", 64'(Ctrl_out), 64'd0);
    chk("inv_memread", 64'(MemRead_out), 64'd0);

    // Hold freezes everything, with a pending hazard present
    load(5'd6); BusA_in = 64'hC0DE; tick();
    for (int i = 0; i < 3; i++) begin
      user_a(5'd6, 64'(100 + i)); Hold = 1; #1;
      chk("hold_stall", 64'(Stall), 64'd0);
      tick();
      chk("hold_busa", BusA_out, 64'hC0DE);
      chk("hold_rw", 64'(RW_out), 64'd6);
    end
    idle(); Valid_in = 1; BusA_in = 64'h99; RW_in = 5'd9; tick();
    chk("rel_busa", BusA_out, 64'h99);
    chk("rel_count", 64'(BubbleCount), 64'd1);

    // Four more bubbles: narrow counter sticks at 3
    for (int i = 0; i < 4; i++) begin
      load(5'(10 + i)); tick();
      user_a(5'(10 + i), 64'(i)); tick();
      tick();
    end
    chk("sat_wide", 64'(BubbleCount), 64'd5);
    chk("sat_narrow", 64'(s_count), 64'd3);

    // Reset beats a hazard
    load(5'd2); tick();
    user_a(5'd2, 64'h1); Reset = 1; tick();
    Reset = 0;
    chk("rh_valid", 64'(Valid_out), 64'd0);
    chk("rh_count", 64'(BubbleCount), 64'd0);
    idle(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
